// File: rtl/parking_meter.sv
// Parking-lot occupancy and billing controller: free-space count plus a single
// customer session (park, bill, post-payment hold) with registered display outputs.
module parking_meter #(
    parameter int CAPACITY     = 40,
    parameter int MAX_HOURS    = 49,
    parameter int DELAY_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power,
    input  logic       car_in,
    input  logic       car_out,
    input  logic       pay,
    input  logic       hour_tick,
    input  logic       is_night,
    output logic [5:0] count,
    output logic       full,
    output logic       need_pay,
    output logic       delay,
    output logic [5:0] time_day,
    output logic [4:0] time_night
);

    localparam int                HOLD_W    = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DELAY_CYCLES - 1);
    localparam logic [5:0]        CAP_VAL   = 6'(CAPACITY);
    localparam logic [6:0]        MAX_VAL   = 7'(MAX_HOURS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PARK = 2'd1,
        BILL = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [5:0]        count_nx;
    logic [5:0]        day_nx;
    logic [4:0]        night_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nx;
    logic [6:0]        hours_total;
    logic              below_cap;

    assign hours_total = {1'b0, time_day} + {2'b00, time_night};
    assign below_cap   = (hours_total < MAX_VAL);

    always_comb begin
        state_nx = state;
        count_nx = count;
        day_nx   = time_day;
        night_nx = time_night;
        hold_nx  = hold_cnt;

        if (!power) begin
            // Power loss abandons the session but keeps the occupancy count.
            state_nx = IDLE;
            day_nx   = '0;
            night_nx = '0;
            hold_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (car_in && (count != 6'd0)) begin
                        state_nx = PARK;
                        count_nx = count - 6'd1;
                        day_nx   = '0;
                        night_nx = '0;
                    end
                end
                PARK: begin
                    if (hour_tick && below_cap) begin
                        if (is_night) begin
                            night_nx = time_night + 5'd1;
                        end else begin
                            day_nx = time_day + 6'd1;
                        end
                    end
                    if (car_out) begin
                        state_nx = BILL;
                        if (count != CAP_VAL) begin
                            count_nx = count + 6'd1;
                        end
                    end
                end
                BILL: begin
                    if (pay) begin
                        state_nx = HOLD;
                        hold_nx  = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    // The cycle that reads zero is the last cycle of the hold.
                    if (hold_cnt == '0) begin
                        state_nx = IDLE;
                        day_nx   = '0;
                        night_nx = '0;
                    end else begin
                        hold_nx = hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Flags are derived from next-state values so they stay aligned with count/state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= CAP_VAL;
            full       <= 1'b0;
            need_pay   <= 1'b0;
            delay      <= 1'b0;
            time_day   <= '0;
            time_night <= '0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            full       <= (count_nx == 6'd0);
            need_pay   <= (state_nx == BILL);
            delay      <= (state_nx == HOLD);
            time_day   <= day_nx;
            time_night <= night_nx;
            hold_cnt   <= hold_nx;
        end
    end

endmodule
